// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipe: load-use interlock, forwarding selects,
// redirect squash, halt and retire count. Define PIPE_HAZARD_PERF_EN for stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int REG_AW = 2,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              stall_all,
   input  logic              mem_busy,
   input  logic              id_valid,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_halt,
   input  logic              id_redirect,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   output logic              pc_write,
   output logic              ir_write,
   output logic [1:0]        fwd_rs_sel,
   output logic [1:0]        fwd_rt_sel,
   output logic              ex_valid,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_to_reg,
   output logic              wb_reg_write,
   output logic [REG_AW-1:0] ex_dst,
   output logic [REG_AW-1:0] mem_dst,
   output logic [REG_AW-1:0] wb_dst,
   output logic [CNT_W-1:0]  num_inst,
`ifdef PIPE_HAZARD_PERF_EN
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_cycles,
`endif
   output logic              is_halted
);
   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              halt;
      logic [REG_AW-1:0] dst;
   } stage_t;

   // WB needs no memory flags once the access is done
   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              halt;
      logic [REG_AW-1:0] dst;
   } wb_t;

   stage_t           ex_q, ex_d, mem_q, mem_d, id_stage;
   wb_t              wb_q, wb_d;
   logic             mem_to_reg_q, mem_to_reg_d;
   logic             squash_q, squash_d;
   logic             halt_pend_q, halt_pend_d;
   logic             is_halted_q, is_halted_d;
   logic [CNT_W-1:0] num_inst_q, num_inst_d;
   logic             id_eff_valid, load_use, id_advance;

   assign id_eff_valid = id_valid & ~squash_q;
   assign load_use     = ex_q.valid & ex_q.mem_read & ex_q.reg_write & id_eff_valid &
                         ((id_uses_rs & (id_rs == ex_q.dst)) | (id_uses_rt & (id_rt == ex_q.dst)));
   assign id_advance   = ~(stall_all | mem_busy | load_use | halt_pend_q);
   assign pc_write     = Reset | id_advance;
   assign ir_write     = pc_write;

   always_comb begin
      fwd_rs_sel = 2'd0;
      fwd_rt_sel = 2'd0;
      if (ex_q.valid && ex_q.reg_write && ex_q.dst == id_rs)       fwd_rs_sel = 2'd1;
      else if (mem_q.valid && mem_q.reg_write && mem_q.dst == id_rs) fwd_rs_sel = 2'd2;
      if (ex_q.valid && ex_q.reg_write && ex_q.dst == id_rt)       fwd_rt_sel = 2'd1;
      else if (mem_q.valid && mem_q.reg_write && mem_q.dst == id_rt) fwd_rt_sel = 2'd2;
   end

   always_comb begin
      id_stage = '0;
      if (id_eff_valid) begin
         id_stage.valid     = 1'b1;
         id_stage.reg_write = id_reg_write;
         id_stage.mem_read  = id_mem_read;
         id_stage.mem_write = id_mem_write;
         id_stage.halt      = id_halt;
         id_stage.dst       = id_dst;
      end
   end

   always_comb begin
      ex_d         = ex_q;
      mem_d        = mem_q;
      wb_d         = wb_q;
      mem_to_reg_d = mem_to_reg_q;
      squash_d     = squash_q;
      halt_pend_d  = halt_pend_q;
      is_halted_d  = is_halted_q;
      num_inst_d   = num_inst_q;
      if (!stall_all) begin
         if (wb_q.valid) begin
            num_inst_d = num_inst_q + CNT_W'(1);
            if (wb_q.halt) is_halted_d = 1'b1;
         end
         if (mem_busy) begin
            wb_d = '0;
         end else begin
            wb_d         = '{valid: mem_q.valid, reg_write: mem_q.reg_write,
                             halt: mem_q.halt, dst: mem_q.dst};
            mem_d        = ex_q;
            mem_to_reg_d = ~ex_q.mem_read;
            ex_d         = '0;
            if (id_advance) begin
               ex_d        = id_stage;
               squash_d    = id_stage.valid & id_redirect;
               halt_pend_d = id_stage.valid & id_halt;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ex_q         <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         mem_to_reg_q <= 1'b0;
         squash_q     <= 1'b1;
         halt_pend_q  <= 1'b0;
         is_halted_q  <= 1'b0;
         num_inst_q   <= '0;
      end else begin
         ex_q         <= ex_d;
         mem_q        <= mem_d;
         wb_q         <= wb_d;
         mem_to_reg_q <= mem_to_reg_d;
         squash_q     <= squash_d;
         halt_pend_q  <= halt_pend_d;
         is_halted_q  <= is_halted_d;
         num_inst_q   <= num_inst_d;
      end
   end

   assign ex_valid     = ex_q.valid;
   assign ex_dst       = ex_q.dst;
   assign mem_read     = mem_q.valid & mem_q.mem_read;
   assign mem_write    = mem_q.valid & mem_q.mem_write;
   assign mem_to_reg   = mem_to_reg_q;
   assign mem_dst      = mem_q.dst;
   assign wb_reg_write = wb_q.valid & wb_q.reg_write;
   assign wb_dst       = wb_q.dst;
   assign num_inst     = num_inst_q;
   assign is_halted    = is_halted_q;

`ifdef PIPE_HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             stall_evt, flush_evt;

   assign stall_evt = ~stall_all & (mem_busy | load_use);
   assign flush_evt = id_advance & squash_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_evt && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_evt && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_cycles = flush_cnt_q;
`else
   // performance counters not built
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; a second instance with CNT_W=4 covers counter wrap.
module tb_pipe_hazard_ctrl;
   logic       Clk = 1'b0;
   logic       Reset, stall_all, mem_busy;
   logic       id_valid, id_reg_write, id_mem_read, id_mem_write, id_halt, id_redirect;
   logic       id_uses_rs, id_uses_rt;
   logic [1:0] id_dst, id_rs, id_rt;

   logic        pc_write, ir_write, ex_valid, mem_read, mem_write, mem_to_reg, wb_reg_write, is_halted;
   logic [1:0]  fwd_rs_sel, fwd_rt_sel, ex_dst, mem_dst, wb_dst;
   logic [15:0] num_inst;

   logic        pc_write_w, ir_write_w, ex_valid_w, mem_read_w, mem_write_w, mem_to_reg_w;
   logic        wb_reg_write_w, is_halted_w;
   logic [1:0]  fwd_rs_sel_w, fwd_rt_sel_w, ex_dst_w, mem_dst_w, wb_dst_w;
   logic [3:0]  num_inst_w;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   pipe_hazard_ctrl #(.REG_AW(2), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .stall_all(stall_all), .mem_busy(mem_busy),
      .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_halt(id_halt), .id_redirect(id_redirect),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_rs(id_rs), .id_rt(id_rt),
      .pc_write(pc_write), .ir_write(ir_write), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .wb_reg_write(wb_reg_write), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
      .num_inst(num_inst), .is_halted(is_halted)
   );

   pipe_hazard_ctrl #(.REG_AW(2), .CNT_W(4)) dut_w (
      .Clk(Clk), .Reset(Reset), .stall_all(stall_all), .mem_busy(mem_busy),
      .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_halt(id_halt), .id_redirect(id_redirect),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_rs(id_rs), .id_rt(id_rt),
      .pc_write(pc_write_w), .ir_write(ir_write_w), .fwd_rs_sel(fwd_rs_sel_w), .fwd_rt_sel(fwd_rt_sel_w),
      .ex_valid(ex_valid_w), .mem_read(mem_read_w), .mem_write(mem_write_w), .mem_to_reg(mem_to_reg_w),
      .wb_reg_write(wb_reg_write_w), .ex_dst(ex_dst_w), .mem_dst(mem_dst_w), .wb_dst(wb_dst_w),
      .num_inst(num_inst_w), .is_halted(is_halted_w)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      id_halt = 0; id_redirect = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_dst = 0; id_rs = 0; id_rt = 0;
   endtask

   task automatic set_alu(input logic [1:0] dst);
      idle();
      id_valid = 1; id_reg_write = 1; id_dst = dst;
   endtask

   // reset, then one idle edge to consume the squashed slot that follows reset
   task automatic do_reset();
      Reset = 1; stall_all = 0; mem_busy = 0; idle();
      step();
      Reset = 0;
      step();
   endtask

   task automatic test_reset();
      Reset = 1; stall_all = 1; mem_busy = 1; idle();
      #1;
      n_tests++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write: got %b want 1", pc_write); end
      step();
      n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
      n_tests++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_wb_rw: got %b want 0", wb_reg_write); end
      n_tests++; if (num_inst !== 16'd0) begin n_fail++; $display("FAIL reset_num_inst: got %0d want 0", num_inst); end
      n_tests++; if (is_halted !== 1'b0) begin n_fail++; $display("FAIL reset_is_halted: got %b want 0", is_halted); end
      n_tests++; if (mem_to_reg !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem: got m2r=%b mr=%b want 0 0", mem_to_reg, mem_read); end
      Reset = 0; stall_all = 0; mem_busy = 0;
      step();
   endtask

   task automatic test_load_use();
      do_reset();
      set_alu(2); id_mem_read = 1;
      step();
      set_alu(3); id_uses_rs = 1; id_rs = 2;
      #1;
      n_tests++; if (pc_write !== 1'b0 || ir_write !== 1'b0) begin n_fail++; $display("FAIL lu_stall: got pc=%b ir=%b want 0 0", pc_write, ir_write); end
      step();
      n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got ex_valid=%b want 0", ex_valid); end
      n_tests++; if (mem_read !== 1'b1 || mem_dst !== 2'd2 || mem_to_reg !== 1'b0) begin n_fail++;
         $display("FAIL lu_mem: got mr=%b dst=%0d m2r=%b want 1 2 0", mem_read, mem_dst, mem_to_reg); end
      n_tests++; if (pc_write !== 1'b1 || fwd_rs_sel !== 2'd2) begin n_fail++;
         $display("FAIL lu_resume: got pc=%b fwd_rs=%0d want 1 2", pc_write, fwd_rs_sel); end
      step();
      n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 2'd3) begin n_fail++; $display("FAIL lu_issue: got v=%b dst=%0d want 1 3", ex_valid, ex_dst); end
      idle();
      step(); step(); step();
      n_tests++; if (num_inst !== 16'd2) begin n_fail++; $display("FAIL lu_count: got %0d want 2", num_inst); end
      // rt-operand path of the interlock
      do_reset();
      set_alu(3); id_mem_read = 1;
      step();
      set_alu(1); id_uses_rt = 1; id_rt = 3;
      #1;
      n_tests++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL lu_rt_stall: got %b want 0", pc_write); end
      idle();
   endtask

   task automatic test_no_false_stall();
      do_reset();
      set_alu(2); id_mem_read = 1;
      step();
      set_alu(1); id_uses_rs = 1; id_rs = 1; id_uses_rt = 1; id_rt = 3;
      #1;
      n_tests++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL nostall_pc: got %b want 1", pc_write); end
      n_tests++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin n_fail++;
         $display("FAIL nostall_fwd: got rs=%0d rt=%0d want 0 0", fwd_rs_sel, fwd_rt_sel); end
      step();
      n_tests++; if (ex_valid !== 1'b1 || ex_dst !== 2'd1 || mem_dst !== 2'd2) begin n_fail++;
         $display("FAIL nostall_adv: got v=%b ex=%0d mem=%0d want 1 1 2", ex_valid, ex_dst, mem_dst); end
      idle();
   endtask

   task automatic test_forward();
      do_reset();
      set_alu(1); step();
      set_alu(1); step();
      set_alu(2); id_rs = 1; id_rt = 1;
      #1;
      n_tests++; if (fwd_rs_sel !== 2'd1 || fwd_rt_sel !== 2'd1) begin n_fail++;
         $display("FAIL fwd_ex_prio: got rs=%0d rt=%0d want 1 1", fwd_rs_sel, fwd_rt_sel); end
      step();
      set_alu(0); id_rs = 1; id_rt = 2;
      #1;
      n_tests++; if (fwd_rs_sel !== 2'd2 || fwd_rt_sel !== 2'd1) begin n_fail++;
         $display("FAIL fwd_mix: got rs=%0d rt=%0d want 2 1", fwd_rs_sel, fwd_rt_sel); end
      idle();
   endtask

   task automatic test_redirect();
      do_reset();
      idle(); id_valid = 1; id_redirect = 1;
      step();
      set_alu(1);
      #1;
      n_tests++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL redir_pc: got %b want 1", pc_write); end
      step();
      n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL redir_squash: got ex_valid=%b want 0", ex_valid); end
      idle();
      step(); step(); step();
      n_tests++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL redir_wb: got %b want 0", wb_reg_write); end
      step();
      n_tests++; if (num_inst !== 16'd1) begin n_fail++; $display("FAIL redir_count: got %0d want 1", num_inst); end
   endtask

   task automatic test_freeze();
      do_reset();
      for (int k = 1; k <= 3; k++) begin set_alu(2'(k)); step(); end
      set_alu(0); stall_all = 1;
      #1;
      n_tests++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL frz_pc: got %b want 0", pc_write); end
      repeat (5) step();
      n_tests++; if (ex_dst !== 2'd3 || mem_dst !== 2'd2 || wb_dst !== 2'd1 || num_inst !== 16'd0) begin n_fail++;
         $display("FAIL frz_hold: got ex=%0d mem=%0d wb=%0d n=%0d want 3 2 1 0", ex_dst, mem_dst, wb_dst, num_inst); end
      stall_all = 0;
      step();
      n_tests++; if (ex_dst !== 2'd0 || mem_dst !== 2'd3 || wb_dst !== 2'd2 || num_inst !== 16'd1 || ex_valid !== 1'b1) begin n_fail++;
         $display("FAIL frz_resume: got ex=%0d mem=%0d wb=%0d n=%0d v=%b want 0 3 2 1 1", ex_dst, mem_dst, wb_dst, num_inst, ex_valid); end
      set_alu(1); stall_all = 1; mem_busy = 1;
      step();
      n_tests++; if (wb_reg_write !== 1'b1 || wb_dst !== 2'd2 || num_inst !== 16'd1) begin n_fail++;
         $display("FAIL both_stall: got wbrw=%b wb=%0d n=%0d want 1 2 1", wb_reg_write, wb_dst, num_inst); end
      stall_all = 0;
      #1;
      n_tests++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL busy_pc: got %b want 0", pc_write); end
      step();
      n_tests++; if (wb_reg_write !== 1'b0 || num_inst !== 16'd2 || mem_dst !== 2'd3 || ex_dst !== 2'd0) begin n_fail++;
         $display("FAIL busy_hold: got wbrw=%b n=%0d mem=%0d ex=%0d want 0 2 3 0", wb_reg_write, num_inst, mem_dst, ex_dst); end
      mem_busy = 0;
      step();
      n_tests++; if (ex_dst !== 2'd1 || mem_dst !== 2'd0 || wb_dst !== 2'd3 || wb_reg_write !== 1'b1 || num_inst !== 16'd2) begin n_fail++;
         $display("FAIL busy_resume: got ex=%0d mem=%0d wb=%0d wbrw=%b n=%0d want 1 0 3 1 2", ex_dst, mem_dst, wb_dst, wb_reg_write, num_inst); end
      idle();
   endtask

   task automatic test_halt();
      do_reset();
      for (int k = 1; k <= 3; k++) begin set_alu(2'(k)); step(); end
      idle(); id_valid = 1; id_halt = 1;
      step();
      set_alu(0);
      #1;
      n_tests++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL halt_pc: got %b want 0", pc_write); end
      step(); step();
      n_tests++; if (is_halted !== 1'b0 || num_inst !== 16'd3) begin n_fail++;
         $display("FAIL halt_pre: got h=%b n=%0d want 0 3", is_halted, num_inst); end
      step();
      n_tests++; if (is_halted !== 1'b1 || num_inst !== 16'd4) begin n_fail++;
         $display("FAIL halt_set: got h=%b n=%0d want 1 4", is_halted, num_inst); end
      repeat (3) step();
      n_tests++; if (num_inst !== 16'd4 || ex_valid !== 1'b0 || is_halted !== 1'b1) begin n_fail++;
         $display("FAIL halt_after: got n=%0d v=%b h=%b want 4 0 1", num_inst, ex_valid, is_halted); end
      idle();
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 17; k++) begin set_alu(2'(k)); step(); end
      idle();
      repeat (3) step();
      n_tests++; if (num_inst_w !== 4'd1) begin n_fail++; $display("FAIL wrap4: got %0d want 1", num_inst_w); end
      n_tests++; if (num_inst !== 16'd17) begin n_fail++; $display("FAIL count16: got %0d want 17", num_inst); end
   endtask

   task automatic test_reset_abort();
      do_reset();
      for (int k = 1; k <= 3; k++) begin set_alu(2'(k)); step(); end
      Reset = 1; stall_all = 1; mem_busy = 1;
      step();
      n_tests++; if (ex_valid !== 1'b0 || wb_reg_write !== 1'b0 || num_inst !== 16'd0) begin n_fail++;
         $display("FAIL abort_clear: got v=%b wbrw=%b n=%0d want 0 0 0", ex_valid, wb_reg_write, num_inst); end
      Reset = 0; stall_all = 0; mem_busy = 0; idle();
      repeat (4) step();
      n_tests++; if (num_inst !== 16'd0) begin n_fail++; $display("FAIL abort_count: got %0d want 0", num_inst); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_forward();
      test_redirect();
      test_freeze();
      test_halt();
      test_wrap();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 2, register-address width (2**REG_AW registers).
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL have ports `Clk` (in, 1, sole clock) and `Reset` (in, 1, synchronous, active-high); one clock, reset synchronous and active-high.
REQ-004 SHALL have ports `stall_all` (in, 1) and `mem_busy` (in, 1): cache freezes the whole pipe, or holds MEM only.
REQ-005 SHALL have decoded-ID input ports, all in, 1 bit unless noted:
- `id_valid`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_halt`, `id_redirect`, `id_uses_rs`, `id_uses_rt`.
- `id_dst`, `id_rs`, `id_rt` (in, REG_AW each).
REQ-006 SHALL have output ports:
- `pc_write`, `ir_write` (1 each): fetch/IR enables.
- `fwd_rs_sel`, `fwd_rt_sel` (2 each): 0 regfile, 1 EX, 2 MEM.
REQ-007 SHALL have output ports `ex_valid`, `mem_read`, `mem_write`, `mem_to_reg`, `wb_reg_write` (1 each) and `ex_dst`, `mem_dst`, `wb_dst` (REG_AW each).
REQ-008 SHALL have output ports `num_inst` (CNT_W, retired count) and `is_halted` (1, sticky halt flag).

Function
REQ-009 SHALL hold three stage registers EX, MEM, WB; each carries valid, reg_write, dst, mem_read, mem_write, halt.
REQ-010 SHALL assert load-use stall, only when all hold:
- EX valid, mem_read and reg_write.
- id_valid.
- (id_uses_rs and id_rs==ex_dst) or (id_uses_rt and id_rt==ex_dst).
REQ-011 SHALL drive pc_write=ir_write=0 when any of stall_all, mem_busy, load-use stall or halt-pending is true; else 1.
REQ-012 SHALL advance nothing when stall_all=1: all stage registers, num_inst and squash flag hold.
REQ-013 SHALL, when mem_busy=1 and stall_all=0: hold MEM, EX and ID; load a bubble (valid=0) into WB; retire the old WB normally.
REQ-014 SHALL, on a load-use stall, load a bubble into EX while MEM and WB advance.
REQ-015 SHALL, on an accepted id_redirect (ID advancing into EX), set a one-cycle squash flag so the next ID instruction enters EX as a bubble.
REQ-016 SHALL treat a squashed ID slot as id_valid=0 for stall and redirect decisions.
REQ-017 SHALL set halt-pending once a halt enters EX; while pending, ID enters EX as a bubble; pending clears only by Reset.
REQ-018 SHALL, on every non-frozen edge with WB valid: increment num_inst modulo 2**CNT_W; set is_halted=1 if the WB halt bit is set.
REQ-019 SHALL select fwd_rs_sel=1 when EX valid, reg_write and ex_dst==id_rs; else 2 when the same holds for MEM; else 0 (EX priority). fwd_rt_sel identical with id_rt.
REQ-020 SHALL compute pc_write, ir_write and fwd selects combinationally; all other outputs SHALL be registered stage fields.
REQ-021 SHALL drive mem_to_reg = NOT MEM.mem_read; mem_read/mem_write SHALL be gated by MEM valid.
REQ-022 SHALL, when stall_all and mem_busy are both 1, obey stall_all.

Reset
REQ-023 SHALL, on Reset=1 at a rising Clk edge, clear all valid bits, halt-pending, is_halted and num_inst, and set the squash flag to 1.
REQ-024 SHALL give Reset priority over stall_all and mem_busy.
REQ-025 SHALL drive all registered outputs to 0 in the cycle after reset; with Reset held, pc_write=1.
REQ-026 SHALL abort in-flight instructions when Reset asserts mid-operation; they are not counted.

Configuration
REQ-027 SHALL, with macro PIPE_HAZARD_PERF_EN defined, add outputs `stall_cycles` and `flush_cycles` (CNT_W each, saturating, reset 0).
- stall_cycles counts edges with load-use or mem_busy stall.
- flush_cycles counts squash bubbles.
REQ-028 SHALL, without PIPE_HAZARD_PERF_EN, omit these ports and counters; all other behaviour identical.

Verification
REQ-029 SHALL cover load-use: EX load dst=2, ID uses rs=2 -> pc_write=0 one cycle, one EX bubble, then fwd_rs_sel=2.
REQ-030 SHALL cover no false stall: EX load dst=2, ID rs=1, rt=3 -> no stall, pc_write=1.
REQ-031 SHALL cover redirect: ID redirect -> next ID instruction never reaches WB; num_inst counts redirect only.
REQ-032 SHALL cover freeze: stall_all high 5 cycles mid-stream -> all state and num_inst unchanged; resumes exactly.
REQ-033 SHALL cover halt: 3 ALU ops then halt -> is_halted=1 the cycle halt leaves WB; num_inst=4; later instructions not counted.
REQ-034 SHALL cover wrap: CNT_W=4, retire 17 instructions -> num_inst=1.
